// File: rtl/ema_pkg.sv
// Shared constants and encodings for the EMA filter family.
package ema_pkg;
  localparam int unsigned W    = 16;
  localparam int unsigned AW   = W + 1;
  localparam int unsigned RW   = 32;
  localparam int unsigned FRAC = W - 1;

  // Unity in the Q1.FRAC alpha format.
  localparam logic [AW-1:0] ONE = AW'(1) << FRAC;

  typedef enum logic [1:0] {
    ALU_IDLE = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_MULT = 2'd2
  } alu_mode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MX,
    S_WX,
    S_MY,
    S_WY,
    S_ADD,
    S_WADD
  } seq_state_e;
endpackage

// File: rtl/ema_alu_seq_if.sv
// Request/result bus between an EMA sequencer and the shared two-operand ALU.
interface ema_alu_seq_if;
  import ema_pkg::*;

  logic signed [W-1:0]  alu_op1_o;
  logic signed [AW-1:0] alu_op2_o;
  logic [1:0]           alu_mode_o;
  logic                 alu_valid_o;
  logic signed [RW-1:0] alu_res_i;
  logic                 alu_valid_i;

  modport master (
    output alu_op1_o, alu_op2_o, alu_mode_o, alu_valid_o,
    input  alu_res_i, alu_valid_i
  );

  modport slave (
    input  alu_op1_o, alu_op2_o, alu_mode_o, alu_valid_o,
    output alu_res_i, alu_valid_i
  );
endinterface

// File: rtl/ema_round_sat.sv
// Round-half-up shift of a Q.FRAC product and saturation of a W+1 bit sum to W bits.
module ema_round_sat
  import ema_pkg::*;
(
  input  logic signed [RW-1:0] prod,
  input  logic signed [W:0]    sum,
  output logic signed [W-1:0]  p_c,
  output logic signed [W-1:0]  y_c
);
  localparam logic signed [RW-1:0] HALF  = RW'(1) << (FRAC - 1);
  localparam logic signed [W-1:0]  Y_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]  Y_MIN = {1'b1, {(W-1){1'b0}}};

  logic signed [RW-1:0] biased;

  // Coefficients never exceed 1.0, so the shifted product always fits W bits.
  assign biased = prod + HALF;
  assign p_c    = W'(biased >>> FRAC);

  // Top two bits disagree only when the sum left the W-bit range.
  always_comb begin
    y_c = sum[W-1:0];
    if (sum[W] != sum[W-1]) begin
      y_c = sum[W] ? Y_MIN : Y_MAX;
    end
  end
endmodule

// File: rtl/ema_alu_seq.sv
// EMA sequencer: drives the shared ALU through two multiplies and an add per sample.
module ema_alu_seq
  import ema_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [W-1:0]  x_i,
  input  logic [AW-1:0]        alpha_i,
  input  logic                 x_valid_i,
  output logic                 x_ready_o,
  ema_alu_seq_if.master        alu,
  output logic signed [W-1:0]  y_o,
  output logic                 y_valid_o
);
  seq_state_e          state;
  logic signed [W-1:0] y_prev;
  logic signed [W-1:0] p1;
  logic [AW-1:0]       b_r;
  logic [AW-1:0]       a_clamp_c;
  logic signed [W-1:0] p_c;
  logic signed [W-1:0] y_c;

  assign a_clamp_c = (alpha_i > ONE) ? ONE : alpha_i;
  assign x_ready_o = (state == S_IDLE);

  ema_round_sat u_round_sat (
    .prod (alu.alu_res_i),
    .sum  ($signed(alu.alu_res_i[W:0])),
    .p_c  (p_c),
    .y_c  (y_c)
  );

  // Requests are loaded on entry to an issue state so valid is high for exactly that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      y_prev          <= '0;
      p1              <= '0;
      b_r             <= '0;
      y_o             <= '0;
      y_valid_o       <= 1'b0;
      alu.alu_op1_o   <= '0;
      alu.alu_op2_o   <= '0;
      alu.alu_mode_o  <= ALU_IDLE;
      alu.alu_valid_o <= 1'b0;
    end else begin
      y_valid_o       <= 1'b0;
      alu.alu_valid_o <= 1'b0;
      alu.alu_mode_o  <= ALU_IDLE;
      case (state)
        S_IDLE: begin
          if (x_valid_i) begin
            b_r             <= ONE - a_clamp_c;
            alu.alu_op1_o   <= x_i;
            alu.alu_op2_o   <= $signed(a_clamp_c);
            alu.alu_mode_o  <= ALU_MULT;
            alu.alu_valid_o <= 1'b1;
            state           <= S_MX;
          end
        end
        S_MX: state <= S_WX;
        S_WX: begin
          if (alu.alu_valid_i) begin
            p1              <= p_c;
            alu.alu_op1_o   <= y_prev;
            alu.alu_op2_o   <= $signed(b_r);
            alu.alu_mode_o  <= ALU_MULT;
            alu.alu_valid_o <= 1'b1;
            state           <= S_MY;
          end
        end
        S_MY: state <= S_WY;
        S_WY: begin
          if (alu.alu_valid_i) begin
            alu.alu_op1_o   <= p1;
            alu.alu_op2_o   <= {p_c[W-1], p_c};
            alu.alu_mode_o  <= ALU_ADD;
            alu.alu_valid_o <= 1'b1;
            state           <= S_ADD;
          end
        end
        S_ADD: state <= S_WADD;
        S_WADD: begin
          if (alu.alu_valid_i) begin
            y_o       <= y_c;
            y_prev    <= y_c;
            y_valid_o <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ema_alu_seq.sv
// Bench for ema_alu_seq: stub ALU plus an arithmetic EMA reference model.
module tb_ema_alu_seq;
  logic               clk;
  logic               rst;
  logic signed [15:0] x_i;
  logic [16:0]        alpha_i;
  logic               x_valid_i;
  logic               x_ready_o;
  logic signed [15:0] y_o;
  logic               y_valid_o;

  ema_alu_seq_if bus ();

  ema_alu_seq dut (
    .clk       (clk),
    .rst       (rst),
    .x_i       (x_i),
    .alpha_i   (alpha_i),
    .x_valid_i (x_valid_i),
    .x_ready_o (x_ready_o),
    .alu       (bus.master),
    .y_o       (y_o),
    .y_valid_o (y_valid_o)
  );

  typedef struct {
    longint op1;
    longint op2;
    longint mode;
  } req_t;

  int     n_cmp = 0;
  int     n_err = 0;
  longint m_y   = 0;
  req_t   exp_req[$];
  int     stall_wy = 0;
  int     req_n    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint rnd(input longint v);
    return (v + 16384) >>> 15;
  endfunction

  // y = round(a*x) + round((1-a)*y_prev), saturated; also lists the ALU requests it implies.
  function automatic longint model_step(input longint xv, input longint av);
    longint a, b, p1, p2, s;
    a = (av > 32768) ? 32768 : av;
    b = 32768 - a;
    p1 = rnd(xv * a);
    p2 = rnd(m_y * b);
    s = p1 + p2;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    exp_req.push_back('{xv, a, 2});
    exp_req.push_back('{m_y, b, 2});
    exp_req.push_back('{p1, p2, 1});
    m_y = s;
    return s;
  endfunction

  // Stub ALU: one-cycle latency, optional extra delay on the second request of a sample.
  initial begin
    bit     pend;
    int     pcnt;
    longint pres;
    req_t   e;
    pend = 0;
    pcnt = 0;
    pres = 0;
    bus.alu_valid_i = 1'b0;
    bus.alu_res_i   = '0;
    forever begin
      @(negedge clk);
      bus.alu_valid_i = 1'b0;
      if (rst) begin
        pend = 0;
      end else begin
        if (pend) begin
          if (pcnt == 0) begin
            bus.alu_valid_i = 1'b1;
            bus.alu_res_i   = 32'(pres);
            pend = 0;
          end else begin
            pcnt--;
          end
        end
        if (bus.alu_valid_o) begin
          chk("req_expected", (exp_req.size() > 0) ? 1 : 0, 1);
          if (exp_req.size() > 0) begin
            e = exp_req.pop_front();
            chk("req_op1", bus.alu_op1_o, e.op1);
            chk("req_op2", bus.alu_op2_o, e.op2);
            chk("req_mode", bus.alu_mode_o, e.mode);
          end
          if (bus.alu_mode_o == 2'd2) pres = longint'(bus.alu_op1_o) * longint'(bus.alu_op2_o);
          else                        pres = longint'(bus.alu_op1_o) + longint'(bus.alu_op2_o);
          pcnt = (req_n == 1) ? stall_wy : 0;
          req_n++;
          pend = 1;
        end
      end
    end
  end

  // One sample with junk upstream traffic while busy; checks latency, value and ready.
  task automatic do_sample(input int xv, input int av, input int extra);
    bit     got;
    longint ey;
    got = 0;
    @(negedge clk);
    chk("ready_idle", x_ready_o, 1);
    ey = model_step(xv, av);
    stall_wy = extra;
    req_n = 0;
    x_i = 16'(xv);
    alpha_i = 17'(av);
    x_valid_i = 1'b1;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      x_valid_i = (k <= 6 + extra) ? 1'($urandom) : 1'b0;
      x_i = 16'($urandom);
      alpha_i = 17'($urandom);
      if (y_valid_o) begin
        got = 1;
        chk("latency", k, 7 + extra);
        chk("y_value", y_o, ey);
        chk("ready_back", x_ready_o, 1);
        chk("req_count", exp_req.size(), 0);
      end else if (k == 1 || k == 6 + extra) begin
        chk("ready_busy", x_ready_o, 0);
      end
    end
    x_valid_i = 1'b0;
    chk("y_valid_seen", got, 1);
  endtask

  initial begin
    int     guard;
    int     sx[4];
    int     sa[4];
    int     si, outs, last;
    bit     adv;
    longint exp_y[$];

    rst = 1'b1;
    x_i = '0;
    alpha_i = '0;
    x_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", x_ready_o, 1);
    chk("rst_y", y_o, 0);
    chk("rst_yv", y_valid_o, 0);
    chk("rst_alu_valid", bus.alu_valid_o, 0);
    chk("rst_alu_mode", bus.alu_mode_o, 0);
    chk("rst_op1", bus.alu_op1_o, 0);
    chk("rst_op2", bus.alu_op2_o, 0);

    // Half-weight steps from zero.
    do_sample(1000, 16384, 0);
    chk("t1_y500", y_o, 500);
    do_sample(1000, 16384, 0);
    chk("t1_y750", y_o, 750);

    // Drive y_prev to full scale so the add overflows.
    guard = 0;
    while (m_y != 32767 && guard < 40) begin
      do_sample(32767, 16384, 0);
      guard++;
    end
    chk("sat_reached", m_y, 32767);
    do_sample(32767, 16384, 0);
    chk("sat_y", y_o, 32767);

    // Alpha above 1.0 clamps; alpha 0 holds the output.
    do_sample(-1234, 40000, 0);
    chk("clamp_y", y_o, -1234);
    do_sample(5000, 0, 0);
    chk("alpha0_y", y_o, -1234);

    // Stalled ALU result on the second multiply.
    do_sample(12345, 20000, 3);

    for (int i = 0; i < 16; i++) begin
      do_sample(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 40000)),
                int'($urandom_range(0, 3)));
    end

    // Back-to-back stream with x_valid held high.
    for (int i = 0; i < 4; i++) begin
      sx[i] = int'($urandom_range(0, 65535)) - 32768;
      sa[i] = int'($urandom_range(0, 32768));
    end
    stall_wy = 0;
    si = 0;
    outs = 0;
    last = -1;
    adv = 0;
    @(negedge clk);
    x_i = 16'(sx[0]);
    alpha_i = 17'(sa[0]);
    x_valid_i = 1'b1;
    for (int cyc = 0; cyc < 100 && outs < 4; cyc++) begin
      if (adv) begin
        adv = 0;
        si++;
        if (si < 4) begin
          x_i = 16'(sx[si]);
          alpha_i = 17'(sa[si]);
        end else begin
          x_valid_i = 1'b0;
        end
      end
      if (y_valid_o) begin
        outs++;
        chk("stream_pending", (exp_y.size() > 0) ? 1 : 0, 1);
        if (exp_y.size() > 0) chk("stream_y", y_o, exp_y.pop_front());
      end
      if (x_valid_i && x_ready_o) begin
        exp_y.push_back(model_step(x_i, alpha_i));
        req_n = 0;
        if (last >= 0) chk("stream_gap", cyc - last, 7);
        last = cyc;
        adv = 1;
      end
      @(negedge clk);
    end
    x_valid_i = 1'b0;
    chk("stream_outs", outs, 4);
    chk("stream_accepts", si, 4);

    // Reset during the second multiply drops the sample.
    do_sample(9000, 30000, 0);
    void'(model_step(7000, 20000));
    req_n = 0;
    x_i = 16'sd7000;
    alpha_i = 17'd20000;
    x_valid_i = 1'b1;
    @(negedge clk);
    x_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_valid", bus.alu_valid_o, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_y", y_o, 0);
    chk("mid_rst_yv", y_valid_o, 0);
    chk("mid_rst_alu_valid", bus.alu_valid_o, 0);
    chk("mid_rst_mode", bus.alu_mode_o, 0);
    chk("mid_rst_op1", bus.alu_op1_o, 0);
    chk("mid_rst_op2", bus.alu_op2_o, 0);
    exp_req.delete();
    m_y = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_sample(200, 32768, 0);
    chk("post_rst_y", y_o, 200);
    do_sample(-3000, 16384, 0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
